// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its helpers.
//   - arb_state_t  : arbiter state encoding (ST_IDLE, ST_BURST)
//   - clog2        : ceiling log2, usable in parameter expressions
//   - DEFAULT_DATA_WIDTH : word width of the asyncfifo write port
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Searches i_last_winner+1, i_last_winner+2, ... modulo NUM_REQ and reports
// the first asserted request.
// Ports:
//   i_req         [NUM_REQ-1:0]  request vector
//   i_last_winner [ID_W-1:0]     index granted most recently
//   o_found                      at least one request is asserted
//   o_idx         [ID_W-1:0]     selected index (0 when o_found=0)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_winner,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    int w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_last_winner) + k) % NUM_REQ;
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = ID_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the asyncfifo write port among
// NUM_REQ requesters in the write clock domain. One requester owns the port
// for a burst of up to MAX_BURST words; one IDLE arbitration cycle precedes
// every grant. Writes are never presented while i_fifo_full is high.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester round-robin, no write
// ST_BURST | r_grant_id owns the port; write whenever req held and not full
//
// Ports:
//   i_wr_clk, i_rst_n             write clock, async active-low reset
//   i_req       [NUM_REQ]         per-requester request (held while data)
//   i_req_data  [NUM_REQ*DW]      flattened words, requester i at [i*DW +: DW]
//   o_ack       [NUM_REQ]         one-hot, word of that requester written now
//   i_fifo_full                   asyncfifo full flag
//   o_fifo_wr_en, o_fifo_write_data   asyncfifo write side
//   o_grant_id  [ID_W]            current owner, valid while o_busy
//   o_busy                        a grant is active
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = clog2(NUM_REQ)
) (
    input  logic                          i_wr_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_write_data,
    output logic [ID_W-1:0]               o_grant_id,
    output logic                          o_busy
);

    localparam int CNT_W = clog2(MAX_BURST) + 1;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  w_grant_id_nxt;
    logic [ID_W-1:0]  r_last_winner;
    logic [ID_W-1:0]  w_last_winner_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;

    logic                  w_found;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req         (i_req),
        .i_last_winner (r_last_winner),
        .o_found       (w_found),
        .o_idx         (w_pick_idx)
    );

    // Live fifo_full gates the write in the same cycle, so a full FIFO never
    // sees wr_en even if full rises right after the previous edge.
    assign w_accept     = (r_state == ST_BURST) && i_req[r_grant_id] && !i_fifo_full;
    assign w_owner_data = i_req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];

    assign o_busy     = (r_state == ST_BURST);
    assign o_grant_id = r_grant_id;

    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_grant_id    <= '0;
            r_last_winner <= ID_W'(NUM_REQ - 1);
            r_burst_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_burst_cnt   <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_id_nxt    = r_grant_id;
        w_last_winner_nxt = r_last_winner;
        w_burst_cnt_nxt   = r_burst_cnt;
        o_ack             = '0;
        o_fifo_wr_en      = 1'b0;
        o_fifo_write_data = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_id_nxt  = w_pick_idx;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = ST_BURST;
                end
            end
            ST_BURST: begin
                o_ack[r_grant_id] = w_accept;
                o_fifo_wr_en      = w_accept;
                if (w_accept) begin
                    o_fifo_write_data = w_owner_data;
                    w_burst_cnt_nxt   = r_burst_cnt + CNT_W'(1);
                end
                // A stall on full with req held falls through: count frozen.
                if ((w_accept && (r_burst_cnt == CNT_W'(MAX_BURST - 1))) || !i_req[r_grant_id]) begin
                    w_last_winner_nxt = r_grant_id;
                    w_burst_cnt_nxt   = '0;
                    w_state_nxt       = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
